rr_burst_arbiter: RTL and testbench

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/rr_pkg.sv | 14 +
 rtl/rr_pick.sv | 37 +++
 rtl/rr_burst_arbiter.sv | 105 ++++++++++
 tb/tb_rr_burst_arbiter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rr_pkg.sv
// Shared types and helpers for the round-robin burst arbiter.
package rr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Width of a binary index into n requesters (never below 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import rr_pkg::*;
#(
  parameter int N = 8,
  parameter int M = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [M-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [M-1:0] pick_id,
  output logic         any
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] iso_dbl;
  logic [N-1:0]   rot;
  logic [N-1:0]   iso;

  // Rotate so ptr lands on bit 0, keep the lowest set bit, rotate back.
  assign req_dbl = {req, req} >> ptr;
  assign rot     = req_dbl[N-1:0];
  assign iso     = rot & (~rot + ONE);
  assign iso_dbl = {iso, iso} << ptr;
  assign pick    = iso_dbl[2*N-1:N];
  assign any     = |req;

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_id = M'(i);
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that holds each grant for a burst of beats, capped at MAX_BURST.
module rr_burst_arbiter
  import rr_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int MAX_BURST = 16,
  localparam int M         = idx_width(N),
  localparam int B         = $clog2(MAX_BURST + 1)
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_en,
  input  logic [N-1:0] i_req,
  input  logic         i_beat,
  input  logic         i_last,
  output logic [N-1:0] o_gnt,
  output logic [M-1:0] o_gnt_id,
  output logic         o_busy,
  output logic [B-1:0] o_beat_cnt
);

  localparam logic [B-1:0] CAP_LAST = B'(MAX_BURST - 1);
  localparam logic [M-1:0] LAST_ID  = M'(N - 1);

  state_t       state_reg, state_next;
  logic [M-1:0] ptr_reg, ptr_next;
  logic [N-1:0] gnt_reg, gnt_next;
  logic [M-1:0] gnt_id_reg, gnt_id_next;
  logic         busy_reg, busy_next;
  logic [B-1:0] beat_cnt_reg, beat_cnt_next;
  logic         grant_end;

  logic [N-1:0] pick;
  logic [M-1:0] pick_id;
  logic         pick_any;

  rr_pick #(.N(N), .M(M)) u_pick (
    .req     (i_req),
    .ptr     (ptr_reg),
    .pick    (pick),
    .pick_id (pick_id),
    .any     (pick_any)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      gnt_id_reg   <= '0;
      busy_reg     <= 1'b0;
      beat_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      gnt_reg      <= gnt_next;
      gnt_id_reg   <= gnt_id_next;
      busy_reg     <= busy_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    gnt_next      = gnt_reg;
    gnt_id_next   = gnt_id_reg;
    busy_next     = busy_reg;
    beat_cnt_next = beat_cnt_reg;
    grant_end     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_en && pick_any) begin
          state_next    = OWN;
          gnt_next      = pick;
          gnt_id_next   = pick_id;
          busy_next     = 1'b1;
          beat_cnt_next = '0;
        end
      end
      OWN: begin
        // An abandoned request ends the grant even if a beat is accepted this cycle.
        grant_end = !i_req[gnt_id_reg] ||
                    (i_beat && (i_last || (beat_cnt_reg == CAP_LAST)));
        if (grant_end) begin
          state_next    = IDLE;
          gnt_next      = '0;
          gnt_id_next   = '0;
          busy_next     = 1'b0;
          beat_cnt_next = '0;
          ptr_next      = (gnt_id_reg == LAST_ID) ? '0 : gnt_id_reg + M'(1);
        end else if (i_beat) begin
          beat_cnt_next = beat_cnt_reg + B'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_gnt      = gnt_reg;
  assign o_gnt_id   = gnt_id_reg;
  assign o_busy     = busy_reg;
  assign o_beat_cnt = beat_cnt_reg;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter with N=4, MAX_BURST=4.
module tb_rr_burst_arbiter;

  localparam int N  = 4;
  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [3:0] req;
  logic       beat;
  logic       last;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic [2:0] cnt;

  int n_checks = 0;
  int n_errors = 0;

  rr_burst_arbiter #(.N(N), .MAX_BURST(MB)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_en       (en),
    .i_req      (req),
    .i_beat     (beat),
    .i_last     (last),
    .o_gnt      (gnt),
    .o_gnt_id   (gnt_id),
    .o_busy     (busy),
    .o_beat_cnt (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic [2:0] c);
    $display("%-14s req=%b en=%b beat=%b last=%b -> gnt=%b id=%0d busy=%b cnt=%0d",
             tag, req, en, beat, last, gnt, gnt_id, busy, cnt);
    check(tag, {22'd0, gnt, gnt_id, busy, cnt}, {22'd0, g, id, b, c});
    check({tag, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; req = 4'b0000; beat = 1'b0; last = 1'b0;
    tick(); tick();
    exp_out("reset", 4'b0000, 2'd0, 1'b0, 3'd0);
    rstn = 1'b1;

    // Fairness: all requesting, each grant ends on its first owned cycle.
    en = 1'b1; req = 4'b1111;
    tick(); exp_out("fair_g0", 4'b0001, 2'd0, 1'b1, 3'd0);
    beat = 1'b1; last = 1'b1;
    tick(); exp_out("fair_idle0", 4'b0000, 2'd0, 1'b0, 3'd0);
    tick(); exp_out("fair_g1", 4'b0010, 2'd1, 1'b1, 3'd0);
    tick(); exp_out("fair_idle1", 4'b0000, 2'd0, 1'b0, 3'd0);
    tick(); exp_out("fair_g2", 4'b0100, 2'd2, 1'b1, 3'd0);
    tick(); exp_out("fair_idle2", 4'b0000, 2'd0, 1'b0, 3'd0);
    tick(); exp_out("fair_g3", 4'b1000, 2'd3, 1'b1, 3'd0);
    tick(); exp_out("fair_idle3", 4'b0000, 2'd0, 1'b0, 3'd0);
    tick(); exp_out("fair_g0b", 4'b0001, 2'd0, 1'b1, 3'd0);
    beat = 1'b0; last = 1'b0; req = 4'b0000;
    tick(); exp_out("drop_g0", 4'b0000, 2'd0, 1'b0, 3'd0);

    // Burst cap: requester 2 alone, continuous beats without last.
    req = 4'b0100;
    tick(); exp_out("cap_g2", 4'b0100, 2'd2, 1'b1, 3'd0);
    beat = 1'b1;
    tick(); exp_out("cap_c1", 4'b0100, 2'd2, 1'b1, 3'd1);
    tick(); exp_out("cap_c2", 4'b0100, 2'd2, 1'b1, 3'd2);
    tick(); exp_out("cap_c3", 4'b0100, 2'd2, 1'b1, 3'd3);
    tick(); exp_out("cap_end", 4'b0000, 2'd0, 1'b0, 3'd0);

    // Wrap from ptr=3: requester 0 first, then 1.
    beat = 1'b0; req = 4'b0011;
    tick(); exp_out("wrap_g0", 4'b0001, 2'd0, 1'b1, 3'd0);
    beat = 1'b1; last = 1'b1;
    tick(); exp_out("wrap_idle", 4'b0000, 2'd0, 1'b0, 3'd0);
    beat = 1'b0; last = 1'b0;
    tick(); exp_out("wrap_g1", 4'b0010, 2'd1, 1'b1, 3'd0);
    beat = 1'b1; last = 1'b1;
    tick(); exp_out("wrap_end", 4'b0000, 2'd0, 1'b0, 3'd0);

    // Abandon: requester 1 owns, late req[3] ignored, req[1] drops after 2 beats.
    beat = 1'b0; last = 1'b0; req = 4'b0010;
    tick(); exp_out("ab_g1", 4'b0010, 2'd1, 1'b1, 3'd0);
    req = 4'b1010; beat = 1'b1;
    tick(); exp_out("ab_c1", 4'b0010, 2'd1, 1'b1, 3'd1);
    tick(); exp_out("ab_c2", 4'b0010, 2'd1, 1'b1, 3'd2);
    req = 4'b1001;
    tick(); exp_out("ab_drop", 4'b0000, 2'd0, 1'b0, 3'd0);
    beat = 1'b0;
    tick(); exp_out("ab_g3", 4'b1000, 2'd3, 1'b1, 3'd0);
    beat = 1'b1; last = 1'b1;
    tick(); exp_out("ab_end", 4'b0000, 2'd0, 1'b0, 3'd0);

    // Enable gating: disabling mid-burst does not disturb the owner.
    beat = 1'b0; last = 1'b0; req = 4'b0001;
    tick(); exp_out("en_g0", 4'b0001, 2'd0, 1'b1, 3'd0);
    en = 1'b0; req = 4'b0111; beat = 1'b1;
    tick(); exp_out("en_c1", 4'b0001, 2'd0, 1'b1, 3'd1);
    last = 1'b1;
    tick(); exp_out("en_end", 4'b0000, 2'd0, 1'b0, 3'd0);
    req = 4'b0110;
    tick(); exp_out("en_block1", 4'b0000, 2'd0, 1'b0, 3'd0);
    tick(); exp_out("en_block2", 4'b0000, 2'd0, 1'b0, 3'd0);
    en = 1'b1; beat = 1'b0; last = 1'b0;
    tick(); exp_out("en_g1", 4'b0010, 2'd1, 1'b1, 3'd0);

    // Reset mid-burst at beat count 3.
    beat = 1'b1;
    tick(); exp_out("rst_c1", 4'b0010, 2'd1, 1'b1, 3'd1);
    tick(); exp_out("rst_c2", 4'b0010, 2'd1, 1'b1, 3'd2);
    tick(); exp_out("rst_c3", 4'b0010, 2'd1, 1'b1, 3'd3);
    #2 rstn = 1'b0;
    #1 exp_out("rst_async", 4'b0000, 2'd0, 1'b0, 3'd0);
    beat = 1'b0; req = 4'b1000;
    tick(); exp_out("rst_hold", 4'b0000, 2'd0, 1'b0, 3'd0);
    rstn = 1'b1;
    tick(); exp_out("rst_g3", 4'b1000, 2'd3, 1'b1, 3'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
